// File: rtl/npu_count_pkg.sv
// rtl/npu_count_pkg.sv - shared count widths, entry type and thermometer decode
package npu_count_pkg;

   localparam int CNT_W   = 4;
   localparam int MASK_W  = 10;
   localparam int CNT_MAX = 10;

   // One FIFO entry: illegal-input flag plus the saturated count
   typedef struct packed {
      logic             err;
      logic [CNT_W-1:0] cnt;
   } cnt_entry_t;

   // Bit i of the mask is set iff i < cnt
   function automatic logic [MASK_W-1:0] thermo_decode(input logic [CNT_W-1:0] cnt);
      logic [MASK_W-1:0] m;
      m = '0;
      for (int i = 0; i < MASK_W; i++) begin
         m[i] = (i < int'(cnt));
      end
      return m;
   endfunction

endpackage

// File: rtl/count_fifo.sv
// rtl/count_fifo.sv - generic show-ahead FIFO with occupancy output
module count_fifo #(
   parameter int W     = 5,
   parameter int DEPTH = 4,
   parameter int PTR_W = 2
) (
   input  logic           clk_i,
   input  logic           rst_ni,
   input  logic           push_i,
   input  logic [W-1:0]   wr_data_i,
   input  logic           pop_i,
   output logic [W-1:0]   rd_data_o,
   output logic [PTR_W:0] level_o
);

   logic [W-1:0]     mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]   level_q, level_d;

   // Pointers wrap naturally because DEPTH is 2**PTR_W; callers gate push/pop
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push_i && !pop_i)      level_d = level_q + 1'b1;
      else if (!push_i && pop_i) level_d = level_q - 1'b1;
   end

   // Control state clears asynchronously; storage contents are left as-is
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   // Storage write, no reset needed since level guards every read
   always_ff @(posedge clk_i) begin
      if (push_i) mem_q[wr_ptr_q] <= wr_data_i;
   end

   assign rd_data_o = mem_q[rd_ptr_q];
   assign level_o   = level_q;

endmodule

// File: rtl/count_expand_10.sv
// rtl/count_expand_10.sv - buffered 4-bit count to 10-bit thermometer mask expander (COUNT_EXPAND_ERRCNT_EN adds err_cnt/err_clr)
module count_expand_10
   import npu_count_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int PTR_W = 2
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CNT_W-1:0]  in_count,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [MASK_W-1:0] out_mask,
   output logic              out_err,
   output logic [PTR_W:0]    level
`ifdef COUNT_EXPAND_ERRCNT_EN
   ,
   input  logic              err_clr,
   output logic [7:0]        err_cnt
`endif
);

   localparam logic [PTR_W:0] FULL_LVL = (PTR_W+1)'(DEPTH);

   cnt_entry_t wr_entry;
   cnt_entry_t head;
   logic       push;
   logic       pop;

   // Saturate illegal counts to a full mask and remember that they were illegal
   always_comb begin
      wr_entry.err = (in_count > CNT_W'(CNT_MAX));
      wr_entry.cnt = wr_entry.err ? CNT_W'(CNT_MAX) : in_count;
   end

   // in_ready is held low while reset is asserted
   assign in_ready  = reset_n && (level != FULL_LVL);
   assign out_valid = (level != '0);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   count_fifo #(
      .W     ($bits(cnt_entry_t)),
      .DEPTH (DEPTH),
      .PTR_W (PTR_W)
   ) u_fifo (
      .clk_i     (clk),
      .rst_ni    (reset_n),
      .push_i    (push),
      .wr_data_i (wr_entry),
      .pop_i     (pop),
      .rd_data_o (head),
      .level_o   (level)
   );

   // Show-ahead decode of the head entry, zeroed when empty
   always_comb begin
      out_mask = '0;
      out_err  = 1'b0;
      if (out_valid) begin
         out_mask = thermo_decode(head.cnt);
         out_err  = head.err;
      end
   end

`ifdef COUNT_EXPAND_ERRCNT_EN
   logic [7:0] err_cnt_q, err_cnt_d;

   // Saturating count of accepted illegal inputs; clear wins over increment
   always_comb begin
      err_cnt_d = err_cnt_q;
      if (err_clr)                                       err_cnt_d = '0;
      else if (push && wr_entry.err && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 1'b1;
   end

   // Error counter register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) err_cnt_q <= '0;
      else          err_cnt_q <= err_cnt_d;
   end

   assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_count_expand_10.sv
// tb/tb_count_expand_10.sv - randomized self-checking bench for count_expand_10
module tb_count_expand_10;

   localparam int DEPTH = 4;
   localparam int PTR_W = 2;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] in_count;
   logic       out_valid;
   logic       out_ready;
   logic [9:0] out_mask;
   logic       out_err;
   logic [2:0] level;
`ifdef COUNT_EXPAND_ERRCNT_EN
   logic       err_clr;
   logic [7:0] err_cnt;
   int         ecnt;
`endif

   int checks = 0;
   int errors = 0;
   int mq[$];

   count_expand_10 #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_count  (in_count),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_mask  (out_mask),
      .out_err   (out_err),
      .level     (level)
`ifdef COUNT_EXPAND_ERRCNT_EN
      ,
      .err_clr   (err_clr),
      .err_cnt   (err_cnt)
`endif
   );

   always #5 clk = ~clk;

   function automatic logic [9:0] exp_mask(input int c);
      int k;
      k = (c > 10) ? 10 : c;
      return 10'((1 << k) - 1);
   endfunction

   function automatic int recount(input logic [9:0] m);
      int s;
      s = 0;
      for (int i = 0; i < 10; i++) s += int'(m[i]);
      return s;
   endfunction

   task automatic cycle(input logic v, input int c, input logic r);
      bit do_push, do_pop;
      in_valid  = v;
      in_count  = 4'(c);
      out_ready = r;
      @(posedge clk);
      do_pop  = r && (mq.size() != 0);
      do_push = v && (mq.size() != DEPTH);
      if (do_pop) void'(mq.pop_front());
      if (do_push) mq.push_back(c);
`ifdef COUNT_EXPAND_ERRCNT_EN
      if (err_clr) ecnt = 0;
      else if (do_push && c > 10 && ecnt < 255) ecnt++;
`endif
      #1;
   endtask

   task automatic test_reset();
      reset_n = 1'b0; in_valid = 1'b0; in_count = '0; out_ready = 1'b0;
`ifdef COUNT_EXPAND_ERRCNT_EN
      err_clr = 1'b0; ecnt = 0;
`endif
      mq.delete();
      repeat (3) @(posedge clk);
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got=%b exp=0", in_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
      checks++; if (out_mask !== 10'd0) begin errors++; $display("FAIL rst_out_mask got=%b exp=0", out_mask); end
      checks++; if (level !== 3'd0) begin errors++; $display("FAIL rst_level got=%0d exp=0", level); end
      reset_n = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL idle_in_ready got=%b exp=1", in_ready); end
      checks++; if (out_valid !== 1'b0 || out_mask !== 10'd0 || level !== 3'd0) begin
         errors++; $display("FAIL idle_outputs valid=%b mask=%b level=%0d exp 0/0/0", out_valid, out_mask, level);
      end
   endtask

   task automatic test_single();
      cycle(1'b1, 3, 1'b1);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid got=%b exp=1", out_valid); end
      checks++; if (out_mask !== 10'b0000000111) begin errors++; $display("FAIL single_mask got=%b exp=0000000111", out_mask); end
      checks++; if (out_err !== 1'b0) begin errors++; $display("FAIL single_err got=%b exp=0", out_err); end
      cycle(1'b0, 0, 1'b1);
      checks++; if (level !== 3'd0 || out_valid !== 1'b0) begin
         errors++; $display("FAIL single_drain level=%0d valid=%b exp 0/0", level, out_valid);
      end
   endtask

   task automatic test_sweep();
      for (int k = 0; k <= 10; k++) begin
         cycle(1'b1, k, 1'b1);
         checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL sweep_valid k=%0d got=%b exp=1", k, out_valid); end
         checks++; if (out_mask !== exp_mask(k)) begin errors++; $display("FAIL sweep_mask k=%0d got=%b exp=%b", k, out_mask, exp_mask(k)); end
         checks++; if (recount(out_mask) != k) begin errors++; $display("FAIL sweep_recount got=%0d exp=%0d", recount(out_mask), k); end
         checks++; if (level !== 3'd1) begin errors++; $display("FAIL sweep_level k=%0d got=%0d exp=1", k, level); end
      end
      cycle(1'b0, 0, 1'b1);
      checks++; if (level !== 3'd0) begin errors++; $display("FAIL sweep_drain got=%0d exp=0", level); end
   endtask

   task automatic test_illegal();
      int vals[2];
      vals[0] = 11; vals[1] = 15;
      for (int i = 0; i < 2; i++) begin
         cycle(1'b1, vals[i], 1'b1);
         checks++; if (out_mask !== 10'h3FF) begin errors++; $display("FAIL illegal_mask c=%0d got=%b exp=1111111111", vals[i], out_mask); end
         checks++; if (out_err !== 1'b1) begin errors++; $display("FAIL illegal_err c=%0d got=%b exp=1", vals[i], out_err); end
      end
      cycle(1'b0, 0, 1'b1);
      checks++; if (out_err !== 1'b0 || out_valid !== 1'b0) begin
         errors++; $display("FAIL illegal_drain err=%b valid=%b exp 0/0", out_err, out_valid);
      end
`ifdef COUNT_EXPAND_ERRCNT_EN
      checks++; if (err_cnt !== 8'd2) begin errors++; $display("FAIL illegal_errcnt got=%0d exp=2", err_cnt); end
`endif
   endtask

   task automatic test_backpressure();
      int cnt[5];
      for (int i = 0; i < 5; i++) cnt[i] = $urandom_range(0, 10);
      for (int i = 0; i < 5; i++) begin
         cycle(1'b1, cnt[i], 1'b0);
         checks++; if (out_mask !== exp_mask(cnt[0])) begin errors++; $display("FAIL bp_stable i=%0d got=%b exp=%b", i, out_mask, exp_mask(cnt[0])); end
         if (i >= 3) begin
            checks++; if (level !== 3'd4) begin errors++; $display("FAIL bp_level i=%0d got=%0d exp=4", i, level); end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready i=%0d got=%b exp=0", i, in_ready); end
         end
      end
      for (int i = 0; i < 4; i++) begin
         checks++; if (out_mask !== exp_mask(cnt[i])) begin errors++; $display("FAIL bp_order i=%0d got=%b exp=%b", i, out_mask, exp_mask(cnt[i])); end
         cycle(1'b0, 0, 1'b1);
      end
      checks++; if (level !== 3'd0 || out_valid !== 1'b0) begin
         errors++; $display("FAIL bp_drain level=%0d valid=%b exp 0/0", level, out_valid);
      end
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 3; i++) cycle(1'b1, $urandom_range(1, 10), 1'b0);
      checks++; if (level !== 3'd3) begin errors++; $display("FAIL mid_level_pre got=%0d exp=3", level); end
      reset_n = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b0 || level !== 3'd0 || out_mask !== 10'd0 || in_ready !== 1'b0) begin
         errors++; $display("FAIL mid_reset valid=%b level=%0d mask=%b ready=%b exp 0/0/0/0", out_valid, level, out_mask, in_ready);
      end
      #3;
      reset_n = 1'b1;
      mq.delete();
`ifdef COUNT_EXPAND_ERRCNT_EN
      ecnt = 0;
`endif
      cycle(1'b0, 0, 1'b1);
      checks++; if (out_valid !== 1'b0 || level !== 3'd0 || out_mask !== 10'd0) begin
         errors++; $display("FAIL mid_stale valid=%b level=%0d mask=%b exp 0/0/0", out_valid, level, out_mask);
      end
      cycle(1'b1, 7, 1'b1);
      checks++; if (out_mask !== exp_mask(7) || level !== 3'd1) begin
         errors++; $display("FAIL mid_after mask=%b level=%0d exp %b/1", out_mask, level, exp_mask(7));
      end
      cycle(1'b0, 0, 1'b1);
   endtask

   task automatic test_random();
      int  c;
      bit  v, hold;
      hold = 1'b0; c = 0;
      for (int n = 0; n < 400; n++) begin
         if (!hold) begin
            v = ($urandom_range(0, 3) != 0);
            c = ($urandom_range(0, 7) == 0) ? $urandom_range(11, 15) : $urandom_range(0, 10);
         end
         hold = v && (mq.size() == DEPTH);
         cycle(v, c, ($urandom_range(0, 2) != 0));
         checks++; if (level !== 3'(mq.size())) begin errors++; $display("FAIL rnd_level n=%0d got=%0d exp=%0d", n, level, mq.size()); end
         checks++; if (out_valid !== (mq.size() != 0)) begin errors++; $display("FAIL rnd_valid n=%0d got=%b", n, out_valid); end
         checks++; if (in_ready !== (mq.size() != DEPTH)) begin errors++; $display("FAIL rnd_ready n=%0d got=%b", n, in_ready); end
         if (mq.size() != 0) begin
            checks++; if (out_mask !== exp_mask(mq[0]) || out_err !== (mq[0] > 10)) begin
               errors++; $display("FAIL rnd_head n=%0d mask=%b err=%b exp count %0d", n, out_mask, out_err, mq[0]);
            end
         end else begin
            checks++; if (out_mask !== 10'd0 || out_err !== 1'b0) begin
               errors++; $display("FAIL rnd_empty n=%0d mask=%b err=%b exp 0/0", n, out_mask, out_err);
            end
         end
`ifdef COUNT_EXPAND_ERRCNT_EN
         checks++; if (err_cnt !== 8'(ecnt)) begin errors++; $display("FAIL rnd_errcnt n=%0d got=%0d exp=%0d", n, err_cnt, ecnt); end
`endif
      end
`ifdef COUNT_EXPAND_ERRCNT_EN
      err_clr = 1'b1;
      cycle(1'b1, 12, 1'b1);
      err_clr = 1'b0;
      checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL errclr_priority got=%0d exp=0", err_cnt); end
`endif
   endtask

   initial begin
      test_reset();
      test_single();
      test_sweep();
      test_illegal();
      test_backpressure();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/count_expand_10.md
Name: count_expand_10

Overview:
- Decompression end of the 10-to-4 ones-count adder used in the NPU accumulation path.
- Accepts a stream of 4-bit ones-counts and emits each one as a 10-bit thermometer mask.
- Feeding an emitted mask back through the 10-to-4 count adder returns the original count, for counts 0..10.
- Contains an input FIFO with valid/ready handshakes on both sides, so a count producer and a mask consumer can be decoupled.

Parameters:
- DEPTH, 4, number of FIFO entries; power of two, at least 2.
- PTR_W, 2, pointer width; equals log2(DEPTH).

Ports:
- clk  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  producer presents a count.
- in_ready  out  1  block can accept a count this cycle.
- in_count  in  4  ones-count; legal range 0..10.
- out_valid  out  1  mask available.
- out_ready  in  1  consumer accepts the mask this cycle.
- out_mask  out  10  thermometer mask; bit i is 1 iff i < count.
- out_err  out  1  the count of the current head entry was illegal (11..15).
- level  out  PTR_W+1  current FIFO occupancy, 0..DEPTH.

Behaviour:
- Reset is asynchronous and active-low.
  - While reset_n=0: write pointer, read pointer and level are 0, and storage contents are don't-care.
  - Outputs during reset: in_ready=0, out_valid=0, out_mask=0, out_err=0, level=0.
  - First cycle after reset_n deasserts: in_ready=1.
- Push occurs when in_valid & in_ready at a rising edge. The entry stored is {err, sat_count}:
  - sat_count = in_count if in_count <= 10, else 10.
  - err = (in_count > 10).
- Pop occurs when out_valid & out_ready at a rising edge.
- in_ready = (level != DEPTH).
  - No pass-through when full: a push and a pop in the same cycle while full is impossible, because in_ready=0.
- out_valid = (level != 0).
  - Output is show-ahead: out_mask and out_err are decoded combinationally from the head entry.
  - out_mask and out_err are forced to 0 when level=0.
- Latency: a count pushed into an empty FIFO at edge N has out_valid=1 from just after edge N. Cycle latency is 1.
- Simultaneous push and pop with 0 < level < DEPTH: level is unchanged and both pointers advance.
- Push only: level+1. Pop only: level-1.
- Pointers wrap modulo DEPTH. There is no overflow or underflow, because both handshakes are gated.
- Stalls:
  - While out_valid=1 and out_ready=0, out_mask and out_err hold stable.
  - The producer must hold in_count stable while in_valid=1 and in_ready=0.
- Decode rules:
  - count=0 gives 10'b0000000000.
  - count=10 gives 10'b1111111111.
  - count=k gives (1<<k)-1.
- Reset asserted mid-operation: all stored entries are discarded immediately (asynchronous) and the outputs return to their reset values.

Optional Feature:
- Macro: COUNT_EXPAND_ERRCNT_EN.
- With the macro defined:
  - Extra output port err_cnt, 8 bits, an error counter.
  - err_cnt increments on every push whose in_count > 10.
  - err_cnt saturates at 255 and resets to 0.
  - Extra input err_clr, 1 bit, synchronous clear. err_clr has priority over an increment in the same cycle.
- Without the macro: neither port exists and there is no counter logic. All other behaviour is identical.

Decomposition:
- Shared package npu_count_pkg holds:
  - CNT_W=4.
  - MASK_W=10.
  - CNT_MAX=10.
  - A typedef for a count entry {err, cnt[3:0]}.
  - The thermometer-decode function.
- One natural sub-module is count_fifo: a generic DEPTH-deep show-ahead FIFO with level output.
- count_expand_10 instantiates count_fifo and adds the saturation, error and decode logic.

Test Plan:
- Reset and idle: hold reset_n=0 for 3 cycles, then release. Expect in_ready=1, out_valid=0, out_mask=0 and level=0.
- Single count: push in_count=3 with out_ready=1. Expect out_valid=1 next cycle, out_mask=10'b0000000111 and out_err=0, then level back to 0 after the pop.
- Full sweep: push counts 0..10 back-to-back with out_ready=1.
  - Each out_mask equals (1<<k)-1.
  - Each mask re-counted by the 10-to-4 count adder model equals k.
  - No gaps occur after the first cycle.
- Illegal values: push 11 and then 15. Expect out_mask=10'b1111111111 with out_err=1 for both. With COUNT_EXPAND_ERRCNT_EN, expect err_cnt=2.
- Backpressure and full: hold out_ready=0 and push 5 counts.
  - After 4 pushes: level=4 and in_ready=0, and the 5th count is not accepted.
  - out_mask is stable at the first entry's mask.
  - Then raise out_ready and expect FIFO-order output.
- Reset mid-stream: with level=3, pulse reset_n low for a half-cycle. Expect immediate out_valid=0 and level=0, and no stale masks after release.
